pattern_tx: RTL and testbench
=============================

# pattern_tx

Serial pattern transmitter that drives the single-bit `x` stream consumed by the team's serial sequence detectors. It loads a parallel pattern on a start request and shifts it out MSB-first, one bit per clock. It then pulses `done` and returns to idle. The block exposes its 3-bit state on `S` in the same way the detectors do, for bench observation and chip-level debug.

## Interface

Parameters:
- `W`, default 8: maximum pattern width in bits.
- `LW`, default `$clog2(W+1)`: width of the `len` input.
- `IDLE_LEVEL`, default 0: value driven on `x` whenever `valid` is low.

Ports:
- `CLK`  in  1  single clock; all state updates on the rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `start`  in  1  frame request; sampled only in IDLE.
- `pattern`  in  W  bits to send; bit W-1 is sent first.
- `len`  in  LW  number of bits to send (0..W; values above W are clamped to W).
- `x`  out  1  serial data to the detector.
- `valid`  out  1  high while `x` carries a pattern bit.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle pulse after the last bit of a frame.
- `S`  out  3  current state encoding.

## Operation

States and `S` encodings:
- IDLE = 3'b000, SEND = 3'b001, DONE = 3'b010. All other encodings are illegal and return to IDLE on the next edge.

IDLE:
- `x` = IDLE_LEVEL, `valid` = 0, `done` = 0.
- If `start`=1 and the effective length is not 0: capture `pattern` into the shift register, capture the effective length into the counter, and go to SEND.
- If `start`=1 and `len`=0: go directly to DONE. No bits are sent.

SEND:
- `x` = shreg[W-1] and `valid` = 1.
- Each cycle: shift shreg left by one, filling with 0, and decrement the counter.
- When the counter equals 1 at the edge, go to DONE.

DONE:
- `done` = 1, `valid` = 0, `x` = IDLE_LEVEL. Go unconditionally to IDLE.

Other rules:
- `start`, `pattern` and `len` are ignored outside IDLE. Changes to them during SEND do not affect the frame in flight.
- `busy` is the decode of S != IDLE. All other outputs are registered, or are a pure decode of registered state.
- RESET takes priority over everything. On the next edge: S=000, `x`=IDLE_LEVEL, `valid`=0, `busy`=0, `done`=0, and the counter and shreg are cleared. An aborted frame produces no `done` pulse.

## Timing

- Reset values: S=000, `x`=IDLE_LEVEL, `valid`=0, `busy`=0, `done`=0.
- Start latency: with `start` sampled at edge k, the first bit is on `x` during cycle k+1.
- A frame of length N occupies cycles k+1..k+N with `valid`=1. `done` is high in cycle k+N+1. The block is back in IDLE at cycle k+N+2.
- For `len`=0, `done` is high in cycle k+1.
- Minimum frame-to-frame period is N+2 cycles. Holding `start` high produces back-to-back frames at that period.
- `start` asserted during the DONE cycle is not accepted. It must still be high in the IDLE cycle that follows.
- Counter arithmetic is LW bits wide. The clamp is effective length = (`len` > W) ? W : `len`, computed before capture.

## Structure

- Shared package `pattern_tx_pkg` holds:
  - the state localparams IDLE, SEND, DONE;
  - the state width constant (3).
- One sub-module, `piso_shreg`: a W-bit parallel-in/serial-out register with `load`, `shift`, `din[W-1:0]` and `sout` = MSB.
- The FSM and the length counter stay in `pattern_tx`.

## Test plan

1. Reset: hold RESET for 2 cycles with `start`=1 → S=000, `x`=0, `valid`=0, `busy`=0, `done`=0 throughout, and no frame starts.
2. Full frame: `pattern`=8'b1011_0010, `len`=8, `start` high for 1 cycle → `x` = 1,0,1,1,0,0,1,0 over the next 8 cycles with `valid`=1. Then `done`=1 for exactly 1 cycle, then S=000.
3. Short and zero length:
   - `pattern`=8'b1100_0000, `len`=3 → `x` = 1,1,0, then `done`.
   - `len`=0 → `valid` never rises and `done` goes high in the cycle after `start`.
4. Held start and input changes: hold `start`=1 with `len`=2 → a new frame begins every 4 cycles. Toggle `pattern` and `len` during SEND → the in-flight bits are unchanged.
5. Reset mid-frame: assert RESET during the 4th bit of an 8-bit frame → next cycle S=000, `valid`=0, `done` never pulses. A fresh `start` then sends a full new frame correctly.
6. Clamp: `len`=12 with W=8 → exactly 8 bits sent, then `done`.

Source files
------------

// File: rtl/pattern_tx_pkg.sv
// rtl/pattern_tx_pkg.sv - shared state encoding for the serial pattern transmitter
package pattern_tx_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 3'b000,
    SEND = 3'b001,
    DONE = 3'b010
  } state_t;

endpackage

// File: rtl/pattern_tx_piso_shreg.sv
// rtl/pattern_tx_piso_shreg.sv - W-bit parallel-in/serial-out register, MSB out first
module piso_shreg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         sout
);

  logic [W-1:0] q;

  // load wins over shift; vacated LSBs fill with zero
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= q << 1;
    end
  end

  assign sout = q[W-1];

endmodule

// File: rtl/pattern_tx.sv
// rtl/pattern_tx.sv - loads a parallel pattern on start and shifts it out MSB-first on x
module pattern_tx
  import pattern_tx_pkg::*;
#(
  parameter int   W          = 8,
  parameter int   LW         = $clog2(W + 1),
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               start,
  input  logic [W-1:0]       pattern,
  input  logic [LW-1:0]      len,
  output logic               x,
  output logic               valid,
  output logic               busy,
  output logic               done,
  output logic [STATE_W-1:0] S
);

  state_t        state_q, state_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] eff_len;
  logic          load, shift, sout;

  assign eff_len = (len > LW'(W)) ? LW'(W) : len;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    shift   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (eff_len != '0) begin
            load    = 1'b1;
            cnt_d   = eff_len;
            state_d = SEND;
          end else begin
            state_d = DONE;
          end
        end
      end
      SEND: begin
        shift = 1'b1;
        cnt_d = cnt_q - LW'(1);
        if (cnt_q == LW'(1)) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  piso_shreg #(.W(W)) u_shreg (
    .clk   (CLK),
    .reset (RESET),
    .load  (load),
    .shift (shift),
    .din   (pattern),
    .sout  (sout)
  );

  // every output is a decode of registered state or the registered shreg MSB
  assign valid = (state_q == SEND);
  assign done  = (state_q == DONE);
  assign busy  = (state_q != IDLE);
  assign x     = valid ? sout : IDLE_LEVEL;
  assign S     = state_q;

endmodule

// File: tb/tb_pattern_tx.sv
// tb/tb_pattern_tx.sv - randomized self-checking bench for pattern_tx against a frame-level model
module tb_pattern_tx;

  logic       CLK;
  logic       RESET;
  logic       start;
  logic [7:0] pattern;
  logic [3:0] len;
  logic       x, valid, busy, done;
  logic [2:0] S;

  int vectors    = 0;
  int miscompares = 0;

  // expected {S, x, valid, busy, done} for upcoming cycles; empty means idle
  logic [6:0] exp_q[$];
  localparam logic [6:0] IDLE_V = 7'b000_0_0_0_0;

  pattern_tx #(.W(8)) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .start   (start),
    .pattern (pattern),
    .len     (len),
    .x       (x),
    .valid   (valid),
    .busy    (busy),
    .done    (done),
    .S       (S)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Observes the current cycle, applies inputs for the next edge and advances the model.
  task automatic step(input logic st, input logic [7:0] pat, input logic [3:0] ln,
                      input logic rst, output logic [6:0] act, output logic [6:0] exp);
    logic was_idle;
    int   n;
    act = {S, x, valid, busy, done};
    was_idle = (exp_q.size() == 0);
    exp = was_idle ? IDLE_V : exp_q[0];
    start = st; pattern = pat; len = ln; RESET = rst;
    if (!was_idle) void'(exp_q.pop_front());
    if (rst) begin
      exp_q.delete();
    end else if (was_idle && st) begin
      n = (ln > 8) ? 8 : int'(ln);
      for (int i = 0; i < n; i++) exp_q.push_back({3'b001, pat[7-i], 1'b1, 1'b1, 1'b0});
      exp_q.push_back({3'b010, 1'b0, 1'b0, 1'b1, 1'b1});
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    logic [6:0] a, e;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'hFF, 4'd8, (i < 2), a, e);
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL reset cyc%0d got %b want %b", i, a, e);
      end
    end
    // the third step released reset with start high; let that frame drain
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 8'h00, 4'd0, 1'b0, a, e);
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL reset_drain cyc%0d got %b want %b", i, a, e);
      end
    end
  endtask

  task automatic test_full_frame();
    logic [6:0] a, e;
    logic [7:0] bits = '0;
    int nv = 0, nd = 0;
    step(1'b1, 8'b1011_0010, 4'd8, 1'b0, a, e);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 8'($urandom), 4'($urandom), 1'b0, a, e);
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL full_frame cyc%0d got %b want %b", i, a, e);
      end
      if (a[2]) begin bits = {bits[6:0], a[3]}; nv++; end
      if (a[0]) nd++;
    end
    vectors++;
    if (bits !== 8'b1011_0010 || nv != 8 || nd != 1) begin
      miscompares++;
      $display("FAIL full_frame_bits got %b/%0d/%0d want 10110010/8/1", bits, nv, nd);
    end
  endtask

  task automatic test_short_zero();
    logic [6:0] a, e;
    logic [2:0] bits = '0;
    int nv = 0;
    step(1'b1, 8'b1100_0000, 4'd3, 1'b0, a, e);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 8'($urandom), 4'($urandom), 1'b0, a, e);
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL short cyc%0d got %b want %b", i, a, e);
      end
      if (a[2]) begin bits = {bits[1:0], a[3]}; nv++; end
    end
    vectors++;
    if (bits !== 3'b110 || nv != 3) begin
      miscompares++;
      $display("FAIL short_bits got %b/%0d want 110/3", bits, nv);
    end
    step(1'b1, 8'($urandom), 4'd0, 1'b0, a, e);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'($urandom), 4'($urandom), 1'b0, a, e);
      vectors++;
      if (a !== e || a[2] !== 1'b0 || a[0] !== (i == 0)) begin
        miscompares++;
        $display("FAIL zero_len cyc%0d got %b want %b", i, a, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] a, e;
    logic [3:0] ln;
    int nd = 0;
    for (int i = 0; i < 16; i++) begin
      ln = (exp_q.size() == 0) ? 4'd2 : 4'($urandom);
      step(1'b1, 8'($urandom), ln, 1'b0, a, e);
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL back_to_back cyc%0d got %b want %b", i, a, e);
      end
      if (a[0]) nd++;
    end
    vectors++;
    if (nd != 4) begin
      miscompares++;
      $display("FAIL back_to_back_dones got %0d want 4", nd);
    end
  endtask

  task automatic test_reset_mid();
    logic [6:0] a, e;
    logic [7:0] pat = 8'($urandom);
    logic [7:0] bits = '0;
    int nd = 0, nv = 0;
    step(1'b1, pat, 4'd8, 1'b0, a, e);
    for (int i = 0; i < 14; i++) begin
      step(1'b0, 8'($urandom), 4'($urandom), (i == 3), a, e);
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL reset_mid cyc%0d got %b want %b", i, a, e);
      end
      if (a[0]) nd++;
      if (i > 3 && a[2]) nv++;
    end
    vectors++;
    if (nd != 0 || nv != 0) begin
      miscompares++;
      $display("FAIL reset_mid_abort got done=%0d valid=%0d want 0/0", nd, nv);
    end
    pat = 8'($urandom);
    nd = 0;
    step(1'b1, pat, 4'd8, 1'b0, a, e);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 8'($urandom), 4'($urandom), 1'b0, a, e);
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL reset_mid_restart cyc%0d got %b want %b", i, a, e);
      end
      if (a[2]) bits = {bits[6:0], a[3]};
      if (a[0]) nd++;
    end
    vectors++;
    if (bits !== pat || nd != 1) begin
      miscompares++;
      $display("FAIL restart_bits got %b/%0d want %b/1", bits, nd, pat);
    end
  endtask

  task automatic test_clamp();
    logic [6:0] a, e;
    int nv = 0, nd = 0;
    step(1'b1, 8'($urandom), 4'd12, 1'b0, a, e);
    for (int i = 0; i < 11; i++) begin
      step(1'b0, 8'($urandom), 4'($urandom), 1'b0, a, e);
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL clamp cyc%0d got %b want %b", i, a, e);
      end
      if (a[2]) nv++;
      if (a[0]) nd++;
    end
    vectors++;
    if (nv != 8 || nd != 1) begin
      miscompares++;
      $display("FAIL clamp_count got %0d bits %0d done want 8/1", nv, nd);
    end
  endtask

  task automatic test_random();
    logic [6:0] a, e;
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 2) != 0, 8'($urandom), 4'($urandom_range(0, 15)),
           $urandom_range(0, 39) == 0, a, e);
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL random cyc%0d got %b want %b", i, a, e);
      end
    end
  endtask

  initial begin
    RESET = 1'b1; start = 1'b1; pattern = '0; len = '0;
    @(posedge CLK);
    #1;
    test_reset();
    test_full_frame();
    test_short_zero();
    test_back_to_back();
    test_reset_mid();
    test_clamp();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
